fifo_uart_tx: RTL
=================

Name: fifo_uart_tx

Overview:
- Read-side consumer of the dual-clock FIFO, running entirely in the FIFO read-clock domain.
- Pops one DWIDTH-bit word at a time from a show-ahead FIFO read port.
- Serialises each word as consecutive 8N1 UART frames, least-significant byte first, on a single registered TX line.
- Bit period is set at run time by a clock divider.

Parameters:
DWIDTH, 32, FIFO word width; must be a multiple of 8 (1 to 8 bytes per word)
BAUD_W, 16, width of the baud divider input

Ports:
clk_i  input  1  block clock (FIFO read clock)
rst_i  input  1  reset; synchronous, active-high
enable_i  input  1  allow new words to be popped
baud_div_i  input  BAUD_W  clocks per bit minus 1
fifo_data_i  input  DWIDTH  FIFO head word; valid whenever fifo_empty_i=0
fifo_empty_i  input  1  FIFO empty flag
fifo_read_o  output  1  pop strobe, one cycle per word
tx_o  output  1  serial line, idle high, registered
busy_o  output  1  word in progress (state != IDLE)

Behaviour:
- Single clock, clk_i.
- Reset is synchronous and active-high on rst_i.
- Reset values: tx_o=1, busy_o=0, fifo_read_o=0, state=IDLE, all counters 0.
- States: IDLE, START, DATA, STOP, plus PARITY when the optional feature is compiled in.

Pop and latency:
- fifo_read_o = (state==IDLE) && enable_i && !fifo_empty_i && !rst_i. It is combinational and never asserted outside IDLE.
- On the pop edge the block captures fifo_data_i into the shift register, captures baud_div_i into the divider reload, sets byte_cnt=0, and moves to START.
- If the pop occurs in cycle T, tx_o goes low from cycle T+1.

Bit timing:
- Every bit lasts exactly div+1 clocks, where div is the value latched at the pop.
- Changing baud_div_i mid-word has no effect until the next pop.
- div=0 is legal and gives 1 clock per bit.

Frame:
- START: drive 0.
- DATA: 8 bits, LSB first, bit counter 0..7.
- STOP: drive 1.
- At the end of STOP:
  - if byte_cnt < DWIDTH/8-1: increment byte_cnt, shift the word right by 8, go to START with no idle gap;
  - otherwise go to IDLE.

Gaps and flow control:
- Between words there is at least one extra IDLE clock with tx_o=1.
- The FIFO flag updates one cycle after a pop. The block never samples fifo_empty_i again until it is back in IDLE, so no double-pop can occur.
- enable_i deasserted mid-word: the current word completes in full, and no further pop happens.
- fifo_empty_i toggling during a word is ignored.
- Reset mid-frame: tx_o=1 on the next cycle. The in-flight word is discarded and not re-read.

Optional Feature:
PARITY_EN
- Defined: a PARITY state sits between DATA and STOP. It drives the even parity of the current byte (XOR of its 8 bits) for div+1 clocks, giving 11-bit frames.
- Undefined: no PARITY state, 10-bit frames, and the PARITY enum value is absent.

Decomposition:
- Package fpgalib_uart_pkg:
  - typedef enum state_t {IDLE, START, DATA, PARITY, STOP};
  - localparam BITS_PER_BYTE=8;
  - function even_parity(byte).
- One natural sub-module, uart_baud_gen:
  - reloadable down-counter with inputs clk_i, rst_i, load, div;
  - output tick, pulsing on the last clock of each bit period.
- The FSM in fifo_uart_tx advances only on tick.

Test Plan:
- DWIDTH=8, div=3, FIFO holds 0xA5:
  - exactly one fifo_read_o pulse;
  - tx_o = 0 then 1,0,1,0,0,1,0,1 then 1, each held 4 clocks (40 clocks total);
  - busy_o falls after the stop bit.
- DWIDTH=32, div=1, word 0x11223344:
  - bytes 0x44,0x33,0x22,0x11 sent as four contiguous frames, 80 clocks with no idle between frames;
  - a single pop.
- FIFO empty, enable_i=1 for 100 clocks: fifo_read_o never asserted, tx_o constant 1, busy_o 0.
- Two queued words:
  - drop enable_i mid-first-word: first word completes, second is not popped;
  - re-raise enable_i: second word is popped the next IDLE cycle.
- Assert rst_i for 1 clock during DATA bit 3: tx_o=1 the next cycle, state IDLE, no extra pop, the next queued word starts cleanly.
- PARITY_EN defined, DWIDTH=8, div=0, data 0x07: frame 0,1,1,1,0,0,0,0,0 then parity 1 then stop 1, 11 clocks.

Source files
------------

// File: rtl/fpgalib_uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
// Optional macro PARITY_EN adds an even-parity bit to every frame.
package fpgalib_uart_pkg;

    localparam int BITS_PER_BYTE = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    function automatic logic even_parity(input logic [BITS_PER_BYTE-1:0] data_byte);
        return ^data_byte;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Reloadable bit-period down-counter; tick marks the last clock of each bit.
module uart_baud_gen #(
    parameter int BAUD_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load,
    input  logic [BAUD_W-1:0] div,
    output logic              tick
);

    logic [BAUD_W-1:0] cnt_reg;
    logic [BAUD_W-1:0] reload_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_reg    <= '0;
            reload_reg <= '0;
        end else if (load) begin
            cnt_reg    <= div;
            reload_reg <= div;
        end else if (cnt_reg == '0) begin
            cnt_reg    <= reload_reg;
        end else begin
            cnt_reg    <= cnt_reg - 1'b1;
        end
    end

    // The load cycle is still IDLE, so a stale tick there must not count.
    assign tick = (cnt_reg == '0) && !load;

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a show-ahead FIFO and sends them LSB byte first as 8N1 frames.
// Define PARITY_EN to insert an even-parity bit between data and stop.
module fifo_uart_tx
    import fpgalib_uart_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int BAUD_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic [BAUD_W-1:0] baud_div_i,
    input  logic [DWIDTH-1:0] fifo_data_i,
    input  logic              fifo_empty_i,
    output logic              fifo_read_o,
    output logic              tx_o,
    output logic              busy_o
);

    localparam int NBYTES = DWIDTH / BITS_PER_BYTE;
    localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    state_t            state_reg, state_next;
    logic [DWIDTH-1:0] shift_reg, shift_next;
    logic [2:0]        bit_cnt_reg, bit_cnt_next;
    logic [BCW-1:0]    byte_cnt_reg, byte_cnt_next;
    logic              tx_reg, tx_next;
    logic              tick;

    uart_baud_gen #(.BAUD_W(BAUD_W)) u_baud (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .load  (fifo_read_o),
        .div   (baud_div_i),
        .tick  (tick)
    );

    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        byte_cnt_next = byte_cnt_reg;
        fifo_read_o   = (state_reg == IDLE) && enable_i && !fifo_empty_i && !rst_i;

        case (state_reg)
            IDLE: begin
                if (fifo_read_o) begin
                    shift_next    = fifo_data_i;
                    bit_cnt_next  = '0;
                    byte_cnt_next = '0;
                    state_next    = START;
                end
            end
            START: begin
                if (tick) begin
                    bit_cnt_next = '0;
                    state_next   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_reg == 3'd7) begin
`ifdef PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                if (tick) state_next = STOP;
            end
`endif
            STOP: begin
                if (tick) begin
                    // Next byte follows back-to-back; the last byte returns to IDLE.
                    if (byte_cnt_reg < BCW'(NBYTES - 1)) begin
                        byte_cnt_next = byte_cnt_reg + 1'b1;
                        shift_next    = shift_reg >> BITS_PER_BYTE;
                        state_next    = START;
                    end else begin
                        state_next    = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Line level is computed from the upcoming state so tx_o stays registered.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[bit_cnt_next];
`ifdef PARITY_EN
            PARITY:  tx_next = even_parity(shift_next[BITS_PER_BYTE-1:0]);
`endif
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            byte_cnt_reg <= '0;
            tx_reg       <= 1'b1;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            bit_cnt_reg  <= bit_cnt_next;
            byte_cnt_reg <= byte_cnt_next;
            tx_reg       <= tx_next;
        end
    end

    assign tx_o   = tx_reg;
    assign busy_o = (state_reg != IDLE);

endmodule
